// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_pkg
//  Description : Shared constants and stage-register helpers for the
//                pipelined carry-lookahead adder/subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package addsub_pkg;

    // Operation select on the M input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Per-rank control bits travelling alongside the operand/result slices
    typedef struct packed {
        logic vld;  // rank holds a live operation
        logic cy;   // carry into the segment this rank computes next
    } stage_ctl_t;

    // Carry-in for segment 0: subtraction is A + ~B + 1
    function automatic logic mode_carry_in(input logic mode);
        return (mode == MODE_SUB);
    endfunction

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/cla_segment.sv
`default_nettype none
// ============================================================================
//  Module      : cla_segment
//  Description : Combinational SEG-bit carry-lookahead adder slice. Produces
//                sum, carry-out and the carry into the slice MSB (needed for
//                signed overflow on the top segment).
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout,
    output logic           o_c_msb
);

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;
    logic [SEG:0]   w_c;
    logic           w_term;
    logic           w_prod;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, flattened
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_prod = 1'b0;
        w_c[0] = i_cin;
        for (int i = 0; i < SEG; i++) begin
            w_term = w_g[i];
            w_prod = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_prod & w_g[j]);
                w_prod = w_prod & w_p[j];
            end
            w_term     = w_term | (w_prod & i_cin);
            w_c[i + 1] = w_term;
        end
    end

    assign o_sum   = w_p ^ w_c[SEG-1:0];
    assign o_cout  = w_c[SEG];
    assign o_c_msb = w_c[SEG-1];

endmodule : cla_segment
`default_nettype wire

// File: rtl/addsub_cla_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_cla_pipe
//  Description : Pipelined signed adder/subtractor. W-bit operands are split
//                into SEG-bit CLA segments, one segment per stage, with the
//                inter-segment carry registered. Valid/ready on both sides.
//                Optional macro ADDSUB_SAT_EN saturates S on signed overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_cla_pipe
    import addsub_pkg::*;
#(
    parameter int W   = 16,
    parameter int SEG = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         M,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic [W-1:0] S,
    output logic         C,
    output logic         V,
    output logic         OUT_VALID,
    input  logic         OUT_READY
);

    localparam int STAGES = W / SEG;
    localparam int c_last = STAGES - 1;

    if (W < 2) begin : g_chk_width
        $error("addsub_cla_pipe: W must be at least 2");
    end
    if ((W % SEG) != 0) begin : g_chk_seg
        $error("addsub_cla_pipe: W must be a multiple of SEG");
    end

    // Rank k feeds segment k: operands (B already conditioned), partial sum
    // of segments below k, and the carry into segment k.
    logic [W-1:0]   r_a   [STAGES];
    logic [W-1:0]   r_b   [STAGES];
    logic [W-1:0]   r_s   [STAGES];
    stage_ctl_t     r_ctl [STAGES];

    logic [W-1:0]   r_out_s;
    logic           r_out_c;
    logic           r_out_v;
    logic           r_out_vld;

    logic [SEG-1:0] w_sum  [STAGES];
    logic           w_cout [STAGES];
    logic           w_cmsb [STAGES];
    logic [W-1:0]   w_mrg  [STAGES];
    logic [W-1:0]   w_res;
    logic           w_ovf;
    logic           w_en;

    // Whole pipe advances unless the output is holding an unaccepted result
    assign w_en     = !(r_out_vld && !OUT_READY);
    assign IN_READY = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        cla_segment #(
            .SEG (SEG)
        ) u_seg (
            .i_a     (r_a[k][k*SEG +: SEG]),
            .i_b     (r_b[k][k*SEG +: SEG]),
            .i_cin   (r_ctl[k].cy),
            .o_sum   (w_sum[k]),
            .o_cout  (w_cout[k]),
            .o_c_msb (w_cmsb[k])
        );
    end

    // Insert each segment's fresh sum bits into the result carried forward
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_mrg[k]               = r_s[k];
            w_mrg[k][k*SEG +: SEG] = w_sum[k];
        end
    end

    // Final result: overflow from top-segment carries, optional clamp
    always_comb begin
        w_ovf = w_cout[c_last] ^ w_cmsb[c_last];
        w_res = w_mrg[c_last];
`ifdef ADDSUB_SAT_EN
        // On overflow both operands share a sign; the A sign picks the rail
        if (w_ovf) begin
            w_res = r_a[c_last][W-1] ? {1'b1, {(W-1){1'b0}}}
                                     : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    // Pipeline ranks and output register; everything holds while stalled
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctl[k] <= '0;
            end
            r_out_vld <= 1'b0;
            r_out_s   <= '0;
            r_out_c   <= 1'b0;
            r_out_v   <= 1'b0;
        end else if (w_en) begin
            r_ctl[0].vld <= IN_VALID;
            r_ctl[0].cy  <= mode_carry_in(M);
            r_a[0]       <= A;
            r_b[0]       <= (M == MODE_SUB) ? ~B : B;
            r_s[0]       <= '0;
            for (int k = 0; k < c_last; k++) begin
                r_ctl[k+1].vld <= r_ctl[k].vld;
                r_ctl[k+1].cy  <= w_cout[k];
                r_a[k+1]       <= r_a[k];
                r_b[k+1]       <= r_b[k];
                r_s[k+1]       <= w_mrg[k];
            end
            r_out_vld <= r_ctl[c_last].vld;
            r_out_s   <= w_res;
            r_out_c   <= w_cout[c_last];
            r_out_v   <= w_ovf;
        end
    end

    assign S         = r_out_s;
    assign C         = r_out_c;
    assign V         = r_out_v;
    assign OUT_VALID = r_out_vld;

endmodule : addsub_cla_pipe
`default_nettype wire

// File: tb/tb_addsub_cla_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_cla_pipe
//  Description : Self-checking bench for addsub_cla_pipe (W=16, SEG=4).
//                Scoreboard queue filled on input transfers, drained on
//                output transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_cla_pipe;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         out_valid;
    logic         out_ready;

    int n_vec = 0;
    int n_err = 0;

    logic [W+1:0] q_exp[$];

    addsub_cla_pipe #(
        .W   (W),
        .SEG (4)
    ) u_dut (
        .CLK       (clk),
        .RST       (rst),
        .A         (a),
        .B         (b),
        .M         (m),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .S         (s),
        .C         (c),
        .V         (v),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: {S, C, V} from plain wide arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                           input logic xm);
        logic [W-1:0] bb;
        logic [W:0]   sum;
        logic [W-1:0] rs;
        logic         ov;
        bb  = xm ? ~xb : xb;
        sum = {1'b0, xa} + {1'b0, bb} + {{W{1'b0}}, xm};
        rs  = sum[W-1:0];
        ov  = (xa[W-1] == bb[W-1]) && (rs[W-1] != xa[W-1]);
`ifdef ADDSUB_SAT_EN
        if (ov) rs = xa[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return {rs, sum[W], ov};
    endfunction

    // Scoreboard: push on input transfer, pop/compare on output transfer
    always @(negedge clk) begin
        if (rst) begin
            q_exp.delete();
        end else begin
            if (in_valid && in_ready) q_exp.push_back(model(a, b, m));
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    logic [W+1:0] e;
                    e = q_exp.pop_front();
                    chk("S", {16'd0, s}, {16'd0, e[W+1:2]});
                    chk("C", {31'd0, c}, {31'd0, e[1]});
                    chk("V", {31'd0, v}, {31'd0, e[0]});
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge
    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xm);
        int guard;
        a        = xa;
        b        = xb;
        m        = xm;
        in_valid = 1'b1;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int cnt;
        cnt = 0;
        while (q_exp.size() != 0 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("drain_empty", q_exp.size(), 32'd0);
    endtask

    task automatic measure_latency(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xm);
        int cnt;
        send(xa, xb, xm);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!out_valid && cnt < 20);
        chk("latency", cnt, 32'd4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        rst       = 1'b1;
        a         = '0;
        b         = '0;
        m         = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_s", {16'd0, s}, 32'd0);
        chk("rst_c", {31'd0, c}, 32'd0);
        chk("rst_v", {31'd0, v}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // First-result latency and directed corner cases
        measure_latency(16'h0001, 16'h0002, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h0003, 16'h0005, 1'b1);
        send(16'h8000, 16'h0001, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
        send(16'h0000, 16'h0000, 1'b1);
        send(16'h7FFF, 16'hFFFF, 1'b1);
        drain();

        // Random operands with occasional bubbles
        for (int i = 0; i < 24; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain();

        // Back-pressure: 8 back-to-back ops, output stalled 3 cycles
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), 1'(i % 2));
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = s;
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                @(posedge clk);
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_s_hold", {16'd0, s}, {16'd0, held});
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    @(posedge clk);
                end
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight
        send(16'h1234, 16'h4321, 1'b0);
        send(16'hABCD, 16'h1111, 1'b1);
        send(16'h7000, 16'h7000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_s", {16'd0, s}, 32'd0);
        chk("midrst_c", {31'd0, c}, 32'd0);
        chk("midrst_v", {31'd0, v}, 32'd0);
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        idle(8);
        measure_latency(16'h1234, 16'h0FFF, 1'b1);
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_addsub_cla_pipe
`default_nettype wire
